wb_regfile_stage: RTL and testbench
===================================

Name: wb_regfile_stage

Overview:
- Consumer end of the MEM/WB pipeline register: the writeback stage plus the general register file (GRF) of the 5-stage MIPS core.
- Inputs:
  - the W-stage instruction word;
  - the W-stage PC values;
  - the W-stage ALU result and extended immediate;
  - the raw data-memory word.
- Function:
  - decodes the W-stage instruction to find the destination register and the write-data source;
  - performs load byte/halfword extraction;
  - commits the write into a 32x32 register array;
  - serves the D-stage read ports, with internal W->D bypass;
  - exports W-stage forwarding information to the hazard/forward unit.

Parameters:
- RESET_PC, 32'h00003000, reset PC (used only by the trace feature).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- w_instr  in  32  W-stage instruction word; 0 = nop.
- w_pc  in  32  W-stage instruction PC.
- w_pc_plus8  in  32  return address for jal/jalr.
- w_alu_res  in  32  ALU result; also the load address (bits [1:0] select byte/half).
- w_ext_imm  in  32  extended immediate (lui value already shifted by 16).
- w_dm_word  in  32  aligned word read from data memory.
- d_rs_addr  in  5  D-stage read address 1.
- d_rt_addr  in  5  D-stage read address 2.
- d_rs_data  out  32  read data 1.
- d_rt_data  out  32  read data 2.
- w_fwd_we  out  1  W stage will write a non-zero register this cycle.
- w_fwd_addr  out  5  W-stage destination register; 0 when no write.
- w_fwd_data  out  32  W-stage write data.

Behaviour:
- Clock and reset: reset reset, synchronous, active-high; clock clk.
- Decode of w_instr (combinational). Write destination and data by instruction:
  - op 0, funct add/addu/sub/subu/and/or/slt/sltu/sll (0x20,0x21,0x22,0x23,0x24,0x25,0x2a,0x2b,0x00): dest = rd, data = w_alu_res.
  - op 0, funct jalr (0x09): dest = rd, data = w_pc_plus8.
  - addi/addiu/slti/andi/ori (op 0x08,0x09,0x0a,0x0c,0x0d): dest = rt, data = w_alu_res.
  - lui (0x0f): dest = rt, data = w_ext_imm.
  - jal (0x03): dest = 31, data = w_pc_plus8.
  - loads: dest = rt, data = extracted load value (below).
  - all others (sw/sb/sh/beq/bne/jr/j/unknown): no write.
- Load extraction, with a = w_alu_res[1:0] (little-endian):
  - lw (0x23): w_dm_word.
  - lb (0x20) / lbu (0x24): byte w_dm_word[8a+7:8a], sign- / zero-extended.
  - lh (0x21) / lhu (0x25): half w_dm_word[16a[1]+15:16a[1]], sign- / zero-extended; a[0] ignored.
- Effective write: we_eff = decoded_write && dest != 0 && !reset.
- Forwarding outputs (combinational from W inputs):
  - w_fwd_we = we_eff.
  - w_fwd_addr = we_eff ? dest : 0.
  - w_fwd_data = we_eff ? data : 0.
- Register array (32x32):
  - On posedge, if reset: all 32 entries <= 0.
  - Else if we_eff: reg[dest] <= data.
  - $0 is never written; it always reads 0.
- Read ports (combinational, zero latency):
  - d_x_data = (d_x_addr != 0 && we_eff && d_x_addr == dest) ? data : reg[d_x_addr].
  - Same-cycle bypass gives D the value being committed this edge (write-before-read semantics).
  - Both ports may hit the bypass simultaneously.
  - d_x_addr == 0 always yields 0.
- Reset values:
  - All registers 0.
  - During reset, the bypass is disabled, so both read ports return 0.
  - w_fwd_* = 0 during reset.
- Reset mid-operation: a pending W-stage write in the reset cycle is dropped.
- Latency:
  - A write is visible on the read ports in the same cycle via the bypass, and from the array on the following cycle.

Optional Feature:
- Macro: WB_TRACE_EN.
- Defined: on each posedge with we_eff = 1, the block executes $display("%d@%h: $%d <= %h", $time, w_pc, dest, data).
  - Exactly one line per committed write.
  - No line for $0, reset, or non-writing instructions.
- Undefined: no display code is compiled; functional behaviour is identical.

Test Plan:
1. Reset for 2 cycles, then read all 32 addresses -> every read returns 0; w_fwd_we = 0.
2. w_instr = ori $t1,$0,0x1234 (0x34091234), w_alu_res = 0x1234 -> same cycle: d_rs_addr = 9 bypasses 0x1234 and w_fwd = {1, 9, 0x1234}. Next cycle with w_instr = 0: the array returns 0x1234.
3. lb $t2,1($0) with w_alu_res = 1, w_dm_word = 0x1280FF34 -> $10 = 0xFFFFFFFF. lbu at address 2 -> 0x00000080. lh at address 2 -> 0x00001280. lhu at address 0 -> 0x0000FF34.
4. jal (0x0C000C00) with w_pc_plus8 = 0x3010 -> $31 = 0x3010. addu $0,$1,$2 with w_alu_res = 5 -> $0 still reads 0, w_fwd_we = 0. sw -> no register changes.
5. add $5 with w_alu_res = 0xAAAA5555 asserted together with reset -> $5 stays 0 after reset deasserts, and d_rs_data = 0 during that cycle.
6. With WB_TRACE_EN defined, run steps 2-4 -> exactly 6 trace lines (ori, 4 loads, jal), each with matching pc/reg/data.

Source files
------------

// File: rtl/wb_regfile_stage.sv
// Writeback stage and 32x32 general register file with same-cycle W->D bypass.
// Optional: define WB_TRACE_EN to print one trace line per committed register write.
module wb_regfile_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] w_instr,
  input  logic [31:0] w_pc,
  input  logic [31:0] w_pc_plus8,
  input  logic [31:0] w_alu_res,
  input  logic [31:0] w_ext_imm,
  input  logic [31:0] w_dm_word,
  input  logic [4:0]  d_rs_addr,
  input  logic [4:0]  d_rt_addr,
  output logic [31:0] d_rs_data,
  output logic [31:0] d_rt_data,
  output logic        w_fwd_we,
  output logic [4:0]  w_fwd_addr,
  output logic [31:0] w_fwd_data
);

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_ADDI    = 6'h08;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_SLTI    = 6'h0a;
  localparam logic [5:0] OP_ANDI    = 6'h0c;
  localparam logic [5:0] OP_ORI     = 6'h0d;
  localparam logic [5:0] OP_LUI     = 6'h0f;
  localparam logic [5:0] OP_LB      = 6'h20;
  localparam logic [5:0] OP_LH      = 6'h21;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_LBU     = 6'h24;
  localparam logic [5:0] OP_LHU     = 6'h25;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_JALR = 6'h09;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_SLT  = 6'h2a;
  localparam logic [5:0] FN_SLTU = 6'h2b;

  typedef enum logic [2:0] {
    SRC_NONE,
    SRC_ALU,
    SRC_PC8,
    SRC_IMM,
    SRC_LOAD
  } wsrc_t;

  logic [5:0]  op;
  logic [5:0]  funct;
  logic [4:0]  rt;
  logic [4:0]  rd;
  wsrc_t       dec_src;
  logic [4:0]  dec_dest;
  logic        dec_write;
  logic        we_eff;
  logic [1:0]  ld_addr;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;
  logic [31:0] wr_data;
  logic [31:0] regs [32];
  logic        unused_bits;

  assign op    = w_instr[31:26];
  assign rt    = w_instr[20:16];
  assign rd    = w_instr[15:11];
  assign funct = w_instr[5:0];

  // rs and shamt fields are consumed upstream; the PC only feeds the trace.
  assign unused_bits = ^{w_instr[25:21], w_instr[10:6], w_pc, RESET_PC};

  always_comb begin
    dec_src  = SRC_NONE;
    dec_dest = 5'd0;
    case (op)
      OP_SPECIAL: begin
        case (funct)
          FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR,
          FN_SLT, FN_SLTU, FN_SLL: begin
            dec_src  = SRC_ALU;
            dec_dest = rd;
          end
          FN_JALR: begin
            dec_src  = SRC_PC8;
            dec_dest = rd;
          end
          default: ;
        endcase
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI: begin
        dec_src  = SRC_ALU;
        dec_dest = rt;
      end
      OP_LUI: begin
        dec_src  = SRC_IMM;
        dec_dest = rt;
      end
      OP_JAL: begin
        dec_src  = SRC_PC8;
        dec_dest = 5'd31;
      end
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
        dec_src  = SRC_LOAD;
        dec_dest = rt;
      end
      default: ;
    endcase
  end

  assign dec_write = (dec_src != SRC_NONE);

  // Little-endian lane select; halfword loads ignore address bit 0.
  assign ld_addr = w_alu_res[1:0];

  always_comb begin
    ld_byte = w_dm_word[7:0];
    case (ld_addr)
      2'd0: ld_byte = w_dm_word[7:0];
      2'd1: ld_byte = w_dm_word[15:8];
      2'd2: ld_byte = w_dm_word[23:16];
      2'd3: ld_byte = w_dm_word[31:24];
      default: ;
    endcase
  end

  assign ld_half = ld_addr[1] ? w_dm_word[31:16] : w_dm_word[15:0];

  always_comb begin
    ld_data = w_dm_word;
    case (op)
      OP_LB:   ld_data = {{24{ld_byte[7]}}, ld_byte};
      OP_LBU:  ld_data = {24'd0, ld_byte};
      OP_LH:   ld_data = {{16{ld_half[15]}}, ld_half};
      OP_LHU:  ld_data = {16'd0, ld_half};
      default: ld_data = w_dm_word;
    endcase
  end

  always_comb begin
    wr_data = 32'd0;
    case (dec_src)
      SRC_ALU:  wr_data = w_alu_res;
      SRC_PC8:  wr_data = w_pc_plus8;
      SRC_IMM:  wr_data = w_ext_imm;
      SRC_LOAD: wr_data = ld_data;
      default:  wr_data = 32'd0;
    endcase
  end

  // A write in the reset cycle is dropped, and $0 is never a real target.
  assign we_eff = dec_write && (dec_dest != 5'd0) && !reset;

  assign w_fwd_we   = we_eff;
  assign w_fwd_addr = we_eff ? dec_dest : 5'd0;
  assign w_fwd_data = we_eff ? wr_data : 32'd0;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= 32'd0;
      end
    end else if (we_eff) begin
      regs[dec_dest] <= wr_data;
    end
  end

  // Write-before-read: D sees the value committing at this edge.
  always_comb begin
    if (reset || d_rs_addr == 5'd0) begin
      d_rs_data = 32'd0;
    end else if (we_eff && d_rs_addr == dec_dest) begin
      d_rs_data = wr_data;
    end else begin
      d_rs_data = regs[d_rs_addr];
    end
  end

  always_comb begin
    if (reset || d_rt_addr == 5'd0) begin
      d_rt_data = 32'd0;
    end else if (we_eff && d_rt_addr == dec_dest) begin
      d_rt_data = wr_data;
    end else begin
      d_rt_data = regs[d_rt_addr];
    end
  end

`ifdef WB_TRACE_EN
  always_ff @(posedge clk) begin
    if (we_eff) begin
      $display("%d@%h: $%d <= %h", $time, w_pc, dec_dest, wr_data);
    end
  end
`endif

endmodule

// File: tb/tb_wb_regfile_stage.sv
// Bench for wb_regfile_stage: directed vector table, reset corner sequences and
// randomized traffic against an array-based register file reference model.
module tb_wb_regfile_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] w_instr;
  logic [31:0] w_pc;
  logic [31:0] w_pc_plus8;
  logic [31:0] w_alu_res;
  logic [31:0] w_ext_imm;
  logic [31:0] w_dm_word;
  logic [4:0]  d_rs_addr;
  logic [4:0]  d_rt_addr;
  logic [31:0] d_rs_data;
  logic [31:0] d_rt_data;
  logic        w_fwd_we;
  logic [4:0]  w_fwd_addr;
  logic [31:0] w_fwd_data;

  int checks = 0;
  int failures = 0;

  logic [31:0] mreg [32];
  logic [31:0] exp_q [$];

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc8;
    logic [31:0] alu;
    logic [31:0] imm;
    logic [31:0] dm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [31:0] e_rs;
    logic [31:0] e_rt;
    logic        e_we;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
  } vec_t;

  vec_t vecs [$];

  wb_regfile_stage #(.RESET_PC(32'h0000_3000)) dut (
    .clk        (clk),
    .reset      (reset),
    .w_instr    (w_instr),
    .w_pc       (w_pc),
    .w_pc_plus8 (w_pc_plus8),
    .w_alu_res  (w_alu_res),
    .w_ext_imm  (w_ext_imm),
    .w_dm_word  (w_dm_word),
    .d_rs_addr  (d_rs_addr),
    .d_rt_addr  (d_rt_addr),
    .d_rs_data  (d_rs_data),
    .d_rt_data  (d_rt_data),
    .w_fwd_we   (w_fwd_we),
    .w_fwd_addr (w_fwd_addr),
    .w_fwd_data (w_fwd_data)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic void ref_wb(input logic rst, input logic [31:0] instr, pc8, alu, imm, dm,
                                 output logic we, output logic [4:0] dest, output logic [31:0] data);
    int unsigned op, fn, a, b, h;
    op = instr >> 26;
    fn = instr & 32'h3f;
    a = alu & 32'h3;
    we = 1'b1;
    dest = 5'd0;
    data = 32'd0;
    if (op == 0 && (fn == 'h20 || fn == 'h21 || fn == 'h22 || fn == 'h23 || fn == 'h24 ||
                    fn == 'h25 || fn == 'h2a || fn == 'h2b || fn == 'h00)) begin
      dest = instr[15:11]; data = alu;
    end else if (op == 0 && fn == 'h09) begin
      dest = instr[15:11]; data = pc8;
    end else if (op == 'h08 || op == 'h09 || op == 'h0a || op == 'h0c || op == 'h0d) begin
      dest = instr[20:16]; data = alu;
    end else if (op == 'h0f) begin
      dest = instr[20:16]; data = imm;
    end else if (op == 'h03) begin
      dest = 5'd31; data = pc8;
    end else if (op == 'h23) begin
      dest = instr[20:16]; data = dm;
    end else if (op == 'h20 || op == 'h24) begin
      dest = instr[20:16];
      b = (dm >> (8 * a)) & 32'hff;
      data = (op == 'h20 && b >= 128) ? (b | 32'hffff_ff00) : b;
    end else if (op == 'h21 || op == 'h25) begin
      dest = instr[20:16];
      h = (dm >> (16 * (a / 2))) & 32'hffff;
      data = (op == 'h21 && h >= 32768) ? (h | 32'hffff_0000) : h;
    end else begin
      we = 1'b0;
    end
    we = we && (dest != 5'd0) && !rst;
  endfunction

  function automatic logic [31:0] ref_read(input logic [4:0] addr, input logic rst, we,
                                           input logic [4:0] dest, input logic [31:0] data);
    if (rst || addr == 5'd0) return 32'd0;
    if (we && addr == dest) return data;
    return mreg[addr];
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input logic rst, input logic [31:0] instr, pc, pc8, alu, imm, dm,
                       input logic [4:0] rs, rt);
    reset = rst;
    w_instr = instr;
    w_pc = pc;
    w_pc_plus8 = pc8;
    w_alu_res = alu;
    w_ext_imm = imm;
    w_dm_word = dm;
    d_rs_addr = rs;
    d_rt_addr = rt;
  endtask

  task automatic commit();
    logic we;
    logic [4:0] dest;
    logic [31:0] data;
    ref_wb(reset, w_instr, w_pc_plus8, w_alu_res, w_ext_imm, w_dm_word, we, dest, data);
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < 32; i++) mreg[i] = 32'd0;
    end else if (we) begin
      mreg[dest] = data;
    end
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic check_model(input string tag);
    logic we;
    logic [4:0] dest;
    logic [31:0] data;
    ref_wb(reset, w_instr, w_pc_plus8, w_alu_res, w_ext_imm, w_dm_word, we, dest, data);
    exp_q.push_back(ref_read(d_rs_addr, reset, we, dest, data));
    exp_q.push_back(ref_read(d_rt_addr, reset, we, dest, data));
    exp_q.push_back({31'd0, we});
    exp_q.push_back(we ? {27'd0, dest} : 32'd0);
    exp_q.push_back(we ? data : 32'd0);
    chk({tag, ".rs_data"}, d_rs_data, exp_q.pop_front());
    chk({tag, ".rt_data"}, d_rt_data, exp_q.pop_front());
    chk({tag, ".fwd_we"}, {31'd0, w_fwd_we}, exp_q.pop_front());
    chk({tag, ".fwd_addr"}, {27'd0, w_fwd_addr}, exp_q.pop_front());
    chk({tag, ".fwd_data"}, w_fwd_data, exp_q.pop_front());
  endtask

  function automatic logic [31:0] rand_instr();
    logic [5:0] op;
    logic [5:0] fn;
    int k;
    k = $urandom_range(0, 15);
    fn = 6'($urandom_range(0, 63));
    op = 6'($urandom_range(0, 63));
    case (k)
      0, 1, 2: begin
        op = 6'h00;
        case ($urandom_range(0, 10))
          0: fn = 6'h20;  1: fn = 6'h21;  2: fn = 6'h22;  3: fn = 6'h23;
          4: fn = 6'h24;  5: fn = 6'h25;  6: fn = 6'h2a;  7: fn = 6'h2b;
          8: fn = 6'h00;  9: fn = 6'h09;  default: fn = 6'h08;
        endcase
      end
      3: case ($urandom_range(0, 4))
           0: op = 6'h08; 1: op = 6'h09; 2: op = 6'h0a; 3: op = 6'h0c; default: op = 6'h0d;
         endcase
      4: op = 6'h0f;
      5: op = 6'h03;
      6: op = 6'h20;
      7: op = 6'h21;
      8: op = 6'h23;
      9: op = 6'h24;
      10: op = 6'h25;
      11: op = ($urandom_range(0, 1) == 0) ? 6'h2b : 6'h28;
      12: op = ($urandom_range(0, 1) == 0) ? 6'h04 : 6'h05;
      13: op = 6'h02;
      default: ;
    endcase
    return {op, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            5'($urandom_range(0, 31)), fn};
  endfunction

  task automatic add_vec(input logic [31:0] instr, pc8, alu, imm, dm, input logic [4:0] rs, rt,
                         input logic [31:0] e_rs, e_rt, input logic e_we,
                         input logic [4:0] e_addr, input logic [31:0] e_data);
    vec_t v;
    v.instr = instr; v.pc8 = pc8; v.alu = alu; v.imm = imm; v.dm = dm;
    v.rs = rs; v.rt = rt; v.e_rs = e_rs; v.e_rt = e_rt;
    v.e_we = e_we; v.e_addr = e_addr; v.e_data = e_data;
    vecs.push_back(v);
  endtask

  // ---------------- test ----------------
  initial begin
    for (int i = 0; i < 32; i++) mreg[i] = 32'd0;

    //       instr         pc8           alu           imm           dm            rs  rt  e_rs          e_rt          we  addr e_data
    add_vec(32'h34091234, 32'h0,       32'h1234,     32'h0,        32'h0,        9,  0,  32'h1234,     32'h0,        1,  9,   32'h1234);
    add_vec(32'h00000000, 32'h0,       32'h0,        32'h0,        32'h0,        9,  9,  32'h1234,     32'h1234,     0,  0,   32'h0);
    add_vec(32'h800A0001, 32'h0,       32'h1,        32'h0,        32'h1280FF34, 10, 9,  32'hFFFFFFFF, 32'h1234,     1,  10,  32'hFFFFFFFF);
    add_vec(32'h900B0002, 32'h0,       32'h2,        32'h0,        32'h1280FF34, 11, 10, 32'h00000080, 32'hFFFFFFFF, 1,  11,  32'h00000080);
    add_vec(32'h840C0002, 32'h0,       32'h2,        32'h0,        32'h1280FF34, 12, 11, 32'h00001280, 32'h00000080, 1,  12,  32'h00001280);
    add_vec(32'h940D0000, 32'h0,       32'h0,        32'h0,        32'h1280FF34, 13, 12, 32'h0000FF34, 32'h00001280, 1,  13,  32'h0000FF34);
    add_vec(32'h840E0003, 32'h0,       32'h3,        32'h0,        32'h1280FF34, 14, 13, 32'h00001280, 32'h0000FF34, 1,  14,  32'h00001280);
    add_vec(32'h8C0F0000, 32'h0,       32'h0,        32'h0,        32'h1280FF34, 15, 14, 32'h1280FF34, 32'h00001280, 1,  15,  32'h1280FF34);
    add_vec(32'h0C000C00, 32'h3010,    32'h0,        32'h0,        32'h0,        31, 15, 32'h3010,     32'h1280FF34, 1,  31,  32'h3010);
    add_vec(32'h00220021, 32'h0,       32'h5,        32'h0,        32'h0,        0,  0,  32'h0,        32'h0,        0,  0,   32'h0);
    add_vec(32'hAC090000, 32'h0,       32'h0,        32'h0,        32'hDEADBEEF, 9,  31, 32'h1234,     32'h3010,     0,  0,   32'h0);
    add_vec(32'h3C10ABCD, 32'h0,       32'h1,        32'hABCD0000, 32'h0,        16, 16, 32'hABCD0000, 32'hABCD0000, 1,  16,  32'hABCD0000);
    add_vec(32'h03E08809, 32'h4444,    32'h7,        32'h0,        32'h0,        17, 0,  32'h4444,     32'h0,        1,  17,  32'h4444);
    add_vec(32'h1000FFFF, 32'h0,       32'h0,        32'h0,        32'h0,        17, 16, 32'h4444,     32'hABCD0000, 0,  0,   32'h0);

    // Reset for two cycles with a writing instruction pending.
    for (int c = 0; c < 2; c++) begin
      drive(1'b1, 32'h34091234, 32'h3000, 32'h3008, 32'h1234, 32'h0, 32'h0, 5'd9, 5'd9);
      @(negedge clk);
      chk("rst.fwd_we", {31'd0, w_fwd_we}, 32'd0);
      chk("rst.fwd_data", w_fwd_data, 32'd0);
      chk("rst.rs_data", d_rs_data, 32'd0);
      commit();
    end

    for (int a = 0; a < 32; a++) begin
      drive(1'b0, 32'h0, 32'h3000, 32'h0, 32'h0, 32'h0, 32'h0, 5'(a), 5'(31 - a));
      @(negedge clk);
      chk("post_rst.rs", d_rs_data, 32'd0);
      chk("post_rst.rt", d_rt_data, 32'd0);
      chk("post_rst.fwd_we", {31'd0, w_fwd_we}, 32'd0);
      commit();
    end

    foreach (vecs[i]) begin
      drive(1'b0, vecs[i].instr, 32'h3000 + 32'(4 * i), vecs[i].pc8, vecs[i].alu, vecs[i].imm,
            vecs[i].dm, vecs[i].rs, vecs[i].rt);
      @(negedge clk);
      chk($sformatf("vec%0d.rs", i), d_rs_data, vecs[i].e_rs);
      chk($sformatf("vec%0d.rt", i), d_rt_data, vecs[i].e_rt);
      chk($sformatf("vec%0d.fwd_we", i), {31'd0, w_fwd_we}, {31'd0, vecs[i].e_we});
      chk($sformatf("vec%0d.fwd_addr", i), {27'd0, w_fwd_addr}, {27'd0, vecs[i].e_addr});
      chk($sformatf("vec%0d.fwd_data", i), w_fwd_data, vecs[i].e_data);
      commit();
    end

    // Write to $5 coinciding with reset must be dropped.
    drive(1'b1, 32'h00002820, 32'h3100, 32'h0, 32'hAAAA5555, 32'h0, 32'h0, 5'd5, 5'd9);
    @(negedge clk);
    chk("rst_mid.rs", d_rs_data, 32'd0);
    chk("rst_mid.rt", d_rt_data, 32'd0);
    chk("rst_mid.fwd_we", {31'd0, w_fwd_we}, 32'd0);
    commit();
    drive(1'b0, 32'h0, 32'h3104, 32'h0, 32'h0, 32'h0, 32'h0, 5'd5, 5'd9);
    @(negedge clk);
    chk("rst_after.r5", d_rs_data, 32'd0);
    chk("rst_after.r9", d_rt_data, 32'd0);
    commit();

    for (int n = 0; n < 500; n++) begin
      drive(($urandom_range(0, 49) == 0), rand_instr(), $urandom, $urandom, $urandom, $urandom,
            $urandom, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      @(negedge clk);
      check_model($sformatf("rnd%0d", n));
      commit();
    end

    for (int a = 0; a < 32; a++) begin
      drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 5'(a), 5'(a ^ 1));
      @(negedge clk);
      check_model($sformatf("sweep%0d", a));
      commit();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
